uart_tx_queue: RTL

Byte queue and frame pacer that sits directly upstream of the UART transmitter. Accepts bytes from a producer through a valid/ready write port, buffers them in a FIFO, and presents one byte at a time on `tx_byte` with a one-cycle `start_transfert` pulse. The transmitter has no busy output, so this block spaces successive pulses by a fixed frame time and never pulses while a frame is in flight.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 80 ++++++++
 rtl/uart_tx_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmit-side blocks.
//   BYTE_W                : width of one UART data byte
//   FRAME_CYCLES_DEFAULT  : default clocks per transmitter frame
//                           (start + 8 data + stop, one clock per bit)
//   txq_state_t           : pacer state encoding for uart_tx_queue
package uart_pkg;

  localparam int BYTE_W               = 8;
  localparam int FRAME_CYCLES_DEFAULT = 10;

  typedef enum logic [0:0] {
    TXQ_IDLE = 1'b0,
    TXQ_WAIT = 1'b1
  } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- single-clock FIFO with separate occupancy counter.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two >= 2).
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   wr_data         : entry to push
//   push_req        : push request; ignored while full (even if a pop
//                     happens on the same edge)
//   pop_req         : pop request; ignored while empty
//   head            : entry at the read pointer (combinational read)
//   full, empty     : derived from the registered count
//   count           : occupied entries
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push_req,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Gated on the registered full flag, so a pop on the same edge never
  // frees room for a push that was offered while full.
  assign push = push_req && !full;
  assign pop  = pop_req && !empty;

  // The consumer registers head itself, so an unregistered read keeps
  // the pop-to-output latency at one edge.
  assign head = mem[rd_ptr_reg];

  // Storage is not reset: stale entries are unreachable once the
  // pointers and count return to zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue -- byte queue and frame pacer feeding a UART transmitter
// that has no busy output. Bytes are buffered and released one at a time
// with a single-cycle start pulse; successive pulses are spaced by
// FRAME_CYCLES+1 clocks so no pulse lands while a frame is in flight.
// Parameters: DEPTH (queue entries, power of two >= 2),
//             FRAME_CYCLES (clocks per transmitter frame, >= 2).
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   wr_data/wr_valid : producer byte and its valid
//   wr_ready         : !full (registered state only, no path from wr_valid)
//   tx_byte          : registered byte to the transmitter
//   start_transfert  : registered one-cycle start pulse
//   full/empty/count : queue occupancy
// Optional (macro UART_TXQ_OVERFLOW_EN):
//   ovf_clr          : clears the overflow flag
//   overflow         : sticky flag, set by any write offered while full;
//                      set wins over a simultaneous clear
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [BYTE_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [BYTE_W-1:0]          tx_byte,
  output logic                       start_transfert,
`ifdef UART_TXQ_OVERFLOW_EN
  input  logic                       ovf_clr,
  output logic                       overflow,
`endif
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int               FC_W       = $clog2(FRAME_CYCLES);
  localparam logic [FC_W-1:0]  FRAME_LOAD = FC_W'(FRAME_CYCLES - 1);

  txq_state_t        state_reg, state_next;
  logic [FC_W-1:0]   frame_cnt_reg, frame_cnt_next;
  logic [BYTE_W-1:0] tx_byte_reg, tx_byte_next;
  logic              start_reg, start_next;
  logic              pop;
  logic [BYTE_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;

  uart_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .push_req (wr_valid),
    .pop_req  (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  assign wr_ready        = !fifo_full;
  assign full            = fifo_full;
  assign empty           = fifo_empty;
  assign tx_byte         = tx_byte_reg;
  assign start_transfert = start_reg;

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= TXQ_IDLE;
      frame_cnt_reg <= '0;
      tx_byte_reg   <= '0;
      start_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      tx_byte_reg   <= tx_byte_next;
      start_reg     <= start_next;
    end
  end

  // Next state. WAIT lasts FRAME_CYCLES edges (counter FRAME_CYCLES-1
  // down to 0) and the following IDLE edge issues the next pulse, which
  // gives the FRAME_CYCLES+1 spacing under backlog.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TXQ_IDLE: if (!fifo_empty)          state_next = TXQ_WAIT;
      TXQ_WAIT: if (frame_cnt_reg == '0)  state_next = TXQ_IDLE;
      default:                            state_next = TXQ_IDLE;
    endcase
  end

  // Outputs: pop, byte load, start pulse and frame counter.
  always_comb begin
    pop            = 1'b0;
    tx_byte_next   = tx_byte_reg;
    start_next     = 1'b0;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      TXQ_IDLE: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          tx_byte_next   = head;
          start_next     = 1'b1;
          frame_cnt_next = FRAME_LOAD;
        end
      end
      TXQ_WAIT: begin
        if (frame_cnt_reg != '0) begin
          frame_cnt_next = frame_cnt_reg - 1'b1;
        end
      end
      default: begin
        frame_cnt_next = '0;
      end
    endcase
  end

`ifdef UART_TXQ_OVERFLOW_EN
  logic overflow_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_reg <= 1'b0;
    end else if (wr_valid && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign overflow = overflow_reg;
`endif

endmodule
